sim_step_controller: RTL and testbench

Sequencer and constraint writer for the Verlet rope array. On each step request it broadcasts one Verlet-integration cycle to all `Node` instances. It then sweeps every node for a fixed number of relaxation iterations: it reads each node's position, computes the constrained position, and writes it back on the node's `x_fix_constraint` / `y_fix_constraint` / `fix_constraint_state` inputs. It sits between the frame/tick logic and the node array.

---
 rtl/sim_step_controller.sv | 184 ++++++++++++++++++
 tb/tb_sim_step_controller.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_step_controller.sv
// sim_step_controller: sequences one Verlet step across the rope node array.
// A step broadcasts a single integrate strobe and then runs ITERATIONS
// relaxation sweeps. Each sweep reads every node, clamps its position to the
// world bounds (node 0 is pinned to the anchor) and writes the result back
// through a one-hot strobe.
module sim_step_controller #(
    parameter int          NUM_NODES  = 8,
    parameter int          ITERATIONS = 2,
    parameter logic [31:0] ANCHOR_X   = 32'h000c8000,
    parameter logic [31:0] ANCHOR_Y   = 32'h0000a000,
    parameter logic [31:0] FLOOR_Y    = 32'h00000000,
    parameter logic [31:0] X_MIN      = 32'h00000000,
    parameter logic [31:0] X_MAX      = 32'h00190000,
    localparam int         SEL_W      = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 step_req,
    input  logic [31:0]          x_in,
    input  logic [31:0]          y_in,
    output logic [SEL_W-1:0]     node_sel,
    output logic                 verlet_state,
    output logic [NUM_NODES-1:0] fix_constraint_state,
    output logic [31:0]          x_fix_constraint,
    output logic [31:0]          y_fix_constraint,
    output logic                 step_busy,
    output logic                 step_done,
    output logic [15:0]          clamp_count
);

    localparam int ITER_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    // Bounds as signed values so the clamp comparisons are two's-complement.
    localparam logic signed [31:0] X_MIN_S   = X_MIN;
    localparam logic signed [31:0] X_MAX_S   = X_MAX;
    localparam logic signed [31:0] FLOOR_Y_S = FLOOR_Y;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VERLET,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    node_q, node_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [31:0]         x_fix_q, y_fix_q;
    logic [15:0]         clamp_cnt_q;
    logic [15:0]         clamp_count_q;

    logic                last_node;
    logic                last_iter;
    logic                in_write;
    logic [31:0]         x_new, y_new;
    logic                altered;

    assign last_node = (node_q == SEL_W'(NUM_NODES - 1));
    assign last_iter = (iter_q == ITER_W'(ITERATIONS - 1));
    assign in_write  = (state_q == S_WRITE);

    // Next-state sequencing and the per-state strobes; outputs derive only
    // from the registered state so an asynchronous reset drops them at once.
    always_comb begin
        state_d      = state_q;
        node_d       = node_q;
        iter_d       = iter_q;
        verlet_state = 1'b0;
        step_busy    = 1'b1;
        step_done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                step_busy = 1'b0;
                if (step_req) begin
                    state_d = S_VERLET;
                end
            end
            S_VERLET: begin
                verlet_state = 1'b1;
                state_d      = S_READ;
            end
            S_READ: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (last_node) begin
                    node_d = '0;
                    if (last_iter) begin
                        iter_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        iter_d  = iter_q + ITER_W'(1);
                        state_d = S_READ;
                    end
                end else begin
                    node_d  = node_q + SEL_W'(1);
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                step_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // One write strobe per node, raised only while that node is in WRITE.
    generate
        for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_fix_strobe
            assign fix_constraint_state[gi] = in_write && (node_q == SEL_W'(gi));
        end
    endgenerate

    // Constraint: pin node 0, otherwise clamp x into [X_MIN, X_MAX] and y to the floor.
    always_comb begin
        x_new = x_in;
        y_new = y_in;
        if (node_q == '0) begin
            x_new = ANCHOR_X;
            y_new = ANCHOR_Y;
        end else begin
            if ($signed(x_in) < X_MIN_S) begin
                x_new = X_MIN;
            end else if ($signed(x_in) > X_MAX_S) begin
                x_new = X_MAX;
            end
            if ($signed(y_in) < FLOOR_Y_S) begin
                y_new = FLOOR_Y;
            end
        end
        altered = (x_new != x_in) || (y_new != y_in);
    end

    // FSM state and node/iteration counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            node_q  <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            node_q  <= node_d;
            iter_q  <= iter_d;
        end
    end

    // Capture the corrected position at the end of READ so WRITE presents it stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_fix_q <= '0;
            y_fix_q <= '0;
        end else if (state_q == S_READ) begin
            x_fix_q <= x_new;
            y_fix_q <= y_new;
        end
    end

    // Count altered writes in the running step (saturating) and publish it in DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clamp_cnt_q   <= '0;
            clamp_count_q <= '0;
        end else begin
            if ((state_q == S_IDLE) && step_req) begin
                clamp_cnt_q <= '0;
            end else if ((state_q == S_READ) && altered && (clamp_cnt_q != 16'hFFFF)) begin
                clamp_cnt_q <= clamp_cnt_q + 16'd1;
            end
            if (state_q == S_DONE) begin
                clamp_count_q <= clamp_cnt_q;
            end
        end
    end

    assign node_sel         = node_q;
    assign x_fix_constraint = x_fix_q;
    assign y_fix_constraint = y_fix_q;
    assign clamp_count      = clamp_count_q;

endmodule

// File: tb/tb_sim_step_controller.sv
// Bench for sim_step_controller: a small node-array environment answers reads
// and absorbs writes, a step-timeline model predicts every output each cycle,
// and directed steps pin the model with hand-computed values.
module tb_sim_step_controller;

    localparam int          N       = 8;
    localparam int          IT      = 2;
    localparam int          DONE_C  = 2 + 2 * IT * N;
    localparam logic [31:0] ANC_X   = 32'h000c8000;
    localparam logic [31:0] ANC_Y   = 32'h0000a000;
    localparam logic [31:0] FLOOR_Y = 32'h00000000;
    localparam logic [31:0] X_MIN   = 32'h00000000;
    localparam logic [31:0] X_MAX   = 32'h00190000;

    logic         clk;
    logic         reset_n;
    logic         step_req;
    logic [31:0]  x_in, y_in;
    logic [2:0]   node_sel;
    logic         verlet_state;
    logic [7:0]   fix;
    logic [31:0]  x_fix, y_fix;
    logic         step_busy, step_done;
    logic [15:0]  clamp_count;

    logic         step_req2;
    logic [31:0]  x_in2, y_in2;
    logic [0:0]   node_sel2;
    logic         verlet2;
    logic [1:0]   fix2;
    logic [31:0]  x_fix2, y_fix2;
    logic         busy2, done2;
    logic [15:0]  clamp2;

    int errors = 0;
    int checks = 0;

    sim_step_controller dut (
        .clk(clk), .reset_n(reset_n), .step_req(step_req),
        .x_in(x_in), .y_in(y_in), .node_sel(node_sel),
        .verlet_state(verlet_state), .fix_constraint_state(fix),
        .x_fix_constraint(x_fix), .y_fix_constraint(y_fix),
        .step_busy(step_busy), .step_done(step_done), .clamp_count(clamp_count)
    );

    sim_step_controller #(.NUM_NODES(2), .ITERATIONS(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .step_req(step_req2),
        .x_in(x_in2), .y_in(y_in2), .node_sel(node_sel2),
        .verlet_state(verlet2), .fix_constraint_state(fix2),
        .x_fix_constraint(x_fix2), .y_fix_constraint(y_fix2),
        .step_busy(busy2), .step_done(done2), .clamp_count(clamp2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected constraint result from the clamp rules.
    function automatic logic [31:0] fx(input int k, input logic [31:0] x);
        if (k == 0) return ANC_X;
        if ($signed(x) < $signed(X_MIN)) return X_MIN;
        if ($signed(x) > $signed(X_MAX)) return X_MAX;
        return x;
    endfunction

    function automatic logic [31:0] fy(input int k, input logic [31:0] y);
        if (k == 0) return ANC_Y;
        if ($signed(y) < $signed(FLOOR_Y)) return FLOOR_Y;
        return y;
    endfunction

    // Node array environment: integrate reloads the test vector, writes store.
    logic [31:0] px[N], py[N], ix[N], iy[N];
    logic [31:0] px2[2], py2[2], ix2[2], iy2[2];

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (verlet_state) begin
                px[k] <= ix[k];
                py[k] <= iy[k];
            end else if (fix[k]) begin
                px[k] <= x_fix;
                py[k] <= y_fix;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (verlet2) begin
                px2[k] <= ix2[k];
                py2[k] <= iy2[k];
            end else if (fix2[k]) begin
                px2[k] <= x_fix2;
                py2[k] <= y_fix2;
            end
        end
    end

    assign x_in  = px[node_sel];
    assign y_in  = py[node_sel];
    assign x_in2 = px2[node_sel2];
    assign y_in2 = py2[node_sel2];

    // Step timeline: cycles elapsed since acceptance (0 = idle).
    int m_c;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)           m_c <= 0;
        else if (m_c == 0)      m_c <= step_req ? 1 : 0;
        else if (m_c == DONE_C) m_c <= 0;
        else                    m_c <= m_c + 1;
    end

    int          m_cnt = 0;
    int          exp_clamp = 0;
    int          cj, ck;
    logic [31:0] ex, ey;
    logic [31:0] cap_x[N], cap_y[N];

    // Per-cycle comparison of the main DUT against the timeline model.
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_busy", step_busy, 0);
            chk("rst_verlet", verlet_state, 0);
            chk("rst_done", step_done, 0);
            chk("rst_fix", fix, 0);
            chk("rst_sel", node_sel, 0);
            chk("rst_clamp", clamp_count, 0);
            chk("rst_xfix", x_fix, 0);
            chk("rst_yfix", y_fix, 0);
            m_cnt     = 0;
            exp_clamp = 0;
        end else begin
            chk("busy", step_busy, m_c != 0);
            chk("verlet", verlet_state, m_c == 1);
            chk("done", step_done, m_c == DONE_C);
            chk("mutex", verlet_state && (fix != 0), 0);
            chk("onehot", $countones(fix) <= 1, 1);
            if (m_c == 1) m_cnt = 0;
            if (m_c >= 2 && m_c < DONE_C) begin
                cj = m_c - 2;
                ck = (cj / 2) % N;
                chk("node_sel", node_sel, ck);
                if (cj % 2 == 1) begin
                    ex = fx(ck, px[ck]);
                    ey = fy(ck, py[ck]);
                    chk("fix_write", fix, 32'd1 << ck);
                    chk("x_fix", x_fix, ex);
                    chk("y_fix", y_fix, ey);
                    if ((ex != px[ck] || ey != py[ck]) && m_cnt < 65535) m_cnt++;
                    if (cj / (2 * N) == 0) begin
                        cap_x[ck] = x_fix;
                        cap_y[ck] = y_fix;
                    end
                end else begin
                    chk("fix_read", fix, 0);
                end
            end else begin
                chk("fix_quiet", fix, 0);
            end
            if (m_c == DONE_C) exp_clamp = m_cnt;
            else chk("clamp_count", clamp_count, exp_clamp);
        end
    end

    // One step on the main DUT; returns done cycle, verlet count/cycle, write count.
    task automatic run_step(output int done_c, output int vn, output int vc, output int wn);
        done_c = -1; vn = 0; vc = -1; wn = 0;
        @(negedge clk);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (verlet_state) begin
                vn++;
                vc = c;
            end
            if (fix != 0) begin
                chk("pattern", fix, 8'd1 << (wn % N));
                wn++;
            end
            if (step_done) begin
                done_c = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic set_vec(input int k, input logic [31:0] x, input logic [31:0] y);
        ix[k] = x;
        iy[k] = y;
    endtask

    int d, vn, vc, wn;
    int dones[$];
    logic [1:0]  wq2[$];
    logic [31:0] wx2[$];

    initial begin
        reset_n   = 1'b0;
        step_req  = 1'b0;
        step_req2 = 1'b0;
        for (int k = 0; k < N; k++) set_vec(k, 32'h00010000 * k, 32'h00020000);
        set_vec(0, 32'h00123000, 32'h00050000);
        ix2[0] = 32'h00000000; iy2[0] = 32'h00000000;
        ix2[1] = 32'h00200000; iy2[1] = 32'h00001000;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic sequence with the anchor pinned from an off-anchor input.
        run_step(d, vn, vc, wn);
        chk("A_done_cycle", d, 34);
        chk("A_verlet_count", vn, 1);
        chk("A_verlet_cycle", vc, 1);
        chk("A_write_count", wn, 16);
        @(negedge clk);
        chk("A_clamp", clamp_count, 1);
        chk("A_anchor_x", cap_x[0], 32'h000c8000);
        chk("A_anchor_y", cap_y[0], 32'h0000a000);

        // Node 3 below both bounds; node 0 already on the anchor.
        set_vec(0, ANC_X, ANC_Y);
        set_vec(3, 32'hFFFFF000, 32'hFFFFE000);
        run_step(d, vn, vc, wn);
        chk("B_done_cycle", d, 34);
        @(negedge clk);
        chk("B_clamp", clamp_count, 1);
        chk("B_x3", cap_x[3], 32'h00000000);
        chk("B_y3", cap_y[3], 32'h00000000);
        chk("B_x5", cap_x[5], 32'h00050000);

        // Node 3 above X_MAX, exact-boundary nodes, and a most-negative node.
        set_vec(3, 32'h001A0000, 32'h00010000);
        set_vec(4, 32'h00190000, 32'h00020000);
        set_vec(5, 32'h00050000, 32'h00000000);
        set_vec(6, 32'h00000000, 32'h00020000);
        set_vec(7, 32'h80000000, 32'h80000000);
        run_step(d, vn, vc, wn);
        @(negedge clk);
        chk("C_clamp", clamp_count, 2);
        chk("C_x3", cap_x[3], 32'h00190000);
        chk("C_x4", cap_x[4], 32'h00190000);
        chk("C_y5", cap_y[5], 32'h00000000);
        chk("C_x6", cap_x[6], 32'h00000000);
        chk("C_x7", cap_x[7], 32'h00000000);
        chk("C_y7", cap_y[7], 32'h00000000);

        // Request held high: steps repeat every 35 cycles.
        @(negedge clk);
        step_req = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (step_done) begin
                dones.push_back(c + 1);
                if (dones.size() == 3) begin
                    step_req = 1'b0;
                    break;
                end
            end
        end
        chk("D_pulses", dones.size(), 3);
        if (dones.size() == 3) begin
            chk("D_first", dones[0], 34);
            chk("D_gap1", dones[1] - dones[0], 35);
            chk("D_gap2", dones[2] - dones[1], 35);
        end
        @(negedge clk);
        chk("D_clamp", clamp_count, 2);
        chk("D_idle", step_busy, 0);

        // Asynchronous reset during a WRITE cycle.
        @(negedge clk);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        repeat (12) @(negedge clk);
        chk("E_pre_fix", fix, 8'h20);
        #2 reset_n = 1'b0;
        #1;
        chk("E_fix", fix, 0);
        chk("E_busy", step_busy, 0);
        chk("E_clamp", clamp_count, 0);
        chk("E_verlet", verlet_state, 0);
        chk("E_xfix", x_fix, 0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        run_step(d, vn, vc, wn);
        chk("E_done_cycle", d, 34);
        chk("E_verlet_cycle", vc, 1);
        @(negedge clk);
        chk("E_clamp_after", clamp_count, 2);

        // Two-node, single-iteration instance.
        @(negedge clk);
        step_req2 = 1'b1;
        @(negedge clk);
        step_req2 = 1'b0;
        d = -1;
        for (int c = 1; c <= 50; c++) begin
            if (fix2 != 0) begin
                wq2.push_back(fix2);
                wx2.push_back(x_fix2);
            end
            chk("F_mutex", verlet2 && (fix2 != 0), 0);
            if (done2) begin
                d = c;
                break;
            end
            @(negedge clk);
        end
        chk("F_done_cycle", d, 6);
        chk("F_writes", wq2.size(), 2);
        if (wq2.size() == 2) begin
            chk("F_w0", wq2[0], 2'b01);
            chk("F_w1", wq2[1], 2'b10);
            chk("F_x0", wx2[0], 32'h000c8000);
            chk("F_x1", wx2[1], 32'h00190000);
        end
        @(negedge clk);
        chk("F_clamp", clamp2, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
